// File: rtl/runway_pkg.sv
// Shared types and constants for the runway arbiter.
// Holds FSM state encodings, ID width, queue depth, fairness and timeout limits.
package runway_pkg;

  localparam int ID_W        = 4;
  localparam int Q_DEPTH     = 4;
  localparam int FAIR_LIMIT  = 2;
  localparam int TIMEOUT_CYC = 16;
  localparam int CNT_W       = $clog2(Q_DEPTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_LAND  = 2'b01,
    S_TKOFF = 2'b10,
    S_LOCK  = 2'b11
  } arb_state_t;

endpackage

// File: rtl/req_fifo.sv
// Small request FIFO; fullness is judged before a same-cycle pop.
// Ports: clk, rst, push/din, pop/dout, full, empty, count (0..DEPTH).
module req_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  // Pointers wrap naturally: DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/runway_arbiter.sv
// Runway arbiter: queues landings/takeoffs and grants one occupant at a time.
// Ports: request pushes, runway_clear, weather inputs; grant outputs, counts,
// drop_err, arb_state. Option RUNWAY_TIMEOUT_EN adds timeout_err.
module runway_arbiter
  import runway_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            land_req,
  input  logic [ID_W-1:0] land_id,
  input  logic            tkoff_req,
  input  logic [ID_W-1:0] tkoff_id,
  input  logic            runway_clear,
  input  logic            severe_weather,
  input  logic            emergency_landing_alert,
  output logic            grant_valid,
  output logic [ID_W-1:0] grant_id,
  output logic            grant_is_land,
  output logic [2:0]      land_count,
  output logic [2:0]      tkoff_count,
  output logic            drop_err,
  output logic [1:0]      arb_state
`ifdef RUNWAY_TIMEOUT_EN
  ,
  output logic            timeout_err
`endif
);

  arb_state_t      state;
  logic [1:0]      fair_cnt;
  logic            land_full, land_empty;
  logic            tk_full, tk_empty;
  logic [ID_W-1:0] land_head, tk_head;
  logic            land_ok, tk_ok, pick_tk, idle_go;
  logic            land_pop, tk_pop;

  req_fifo #(.DEPTH(Q_DEPTH), .WIDTH(ID_W)) u_land_q (
    .clk(clk), .rst(rst),
    .push(land_req), .din(land_id),
    .pop(land_pop), .dout(land_head),
    .full(land_full), .empty(land_empty),
    .count(land_count)
  );

  req_fifo #(.DEPTH(Q_DEPTH), .WIDTH(ID_W)) u_tkoff_q (
    .clk(clk), .rst(rst),
    .push(tkoff_req), .din(tkoff_id),
    .pop(tk_pop), .dout(tk_head),
    .full(tk_full), .empty(tk_empty),
    .count(tkoff_count)
  );

  // Takeoff wins when it is the only candidate, or after a landing streak.
  assign land_ok  = ~land_empty;
  assign tk_ok    = ~tk_empty & ~severe_weather;
  assign pick_tk  = tk_ok & (~land_ok | (fair_cnt >= 2'(FAIR_LIMIT)));
  assign idle_go  = (state == S_IDLE) & ~emergency_landing_alert;
  assign land_pop = idle_go & land_ok & ~pick_tk;
  assign tk_pop   = idle_go & pick_tk;
  assign arb_state = state;

`ifdef RUNWAY_TIMEOUT_EN
  logic [4:0] tmo_cnt;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_IDLE;
      grant_valid   <= 1'b0;
      grant_id      <= '0;
      grant_is_land <= 1'b0;
      drop_err      <= 1'b0;
      fair_cnt      <= '0;
`ifdef RUNWAY_TIMEOUT_EN
      tmo_cnt       <= '0;
      timeout_err   <= 1'b0;
`endif
    end else begin
      grant_valid <= 1'b0;
      drop_err    <= (land_req & land_full) | (tkoff_req & tk_full);
`ifdef RUNWAY_TIMEOUT_EN
      timeout_err <= 1'b0;
`endif
      unique case (state)
        S_IDLE: begin
          if (emergency_landing_alert) begin
            state <= S_LOCK;
          end else if (land_pop) begin
            state         <= S_LAND;
            grant_valid   <= 1'b1;
            grant_id      <= land_head;
            grant_is_land <= 1'b1;
            if (fair_cnt < 2'(FAIR_LIMIT)) fair_cnt <= fair_cnt + 1'b1;
          end else if (tk_pop) begin
            state         <= S_TKOFF;
            grant_valid   <= 1'b1;
            grant_id      <= tk_head;
            grant_is_land <= 1'b0;
            fair_cnt      <= '0;
          end
        end
        S_LAND, S_TKOFF: begin
`ifdef RUNWAY_TIMEOUT_EN
          if (runway_clear) begin
            state   <= S_IDLE;
            tmo_cnt <= '0;
          end else if (tmo_cnt == 5'(TIMEOUT_CYC - 1)) begin
            state       <= S_IDLE;
            tmo_cnt     <= '0;
            timeout_err <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
`else
          if (runway_clear) state <= S_IDLE;
`endif
        end
        S_LOCK: begin
          if (!emergency_landing_alert) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_runway_arbiter.sv
// Directed scoreboard bench for runway_arbiter.
// Stimulus pushes expected grants; a negedge monitor pops and compares.
module tb_runway_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       land_req, tkoff_req, runway_clear;
  logic [3:0] land_id, tkoff_id;
  logic       severe_weather, emergency_landing_alert;
  logic       grant_valid, grant_is_land, drop_err;
  logic [3:0] grant_id;
  logic [2:0] land_count, tkoff_count;
  logic [1:0] arb_state;
`ifdef RUNWAY_TIMEOUT_EN
  logic       timeout_err;
`endif

  typedef struct {
    logic [3:0] id;
    logic       land;
  } gnt_t;

  gnt_t exp_q[$];
  int   n_pass = 0;
  int   n_chk  = 0;

  always #5 clk = ~clk;

  runway_arbiter dut (
    .clk(clk), .rst(rst),
    .land_req(land_req), .land_id(land_id),
    .tkoff_req(tkoff_req), .tkoff_id(tkoff_id),
    .runway_clear(runway_clear),
    .severe_weather(severe_weather),
    .emergency_landing_alert(emergency_landing_alert),
    .grant_valid(grant_valid), .grant_id(grant_id),
    .grant_is_land(grant_is_land),
    .land_count(land_count), .tkoff_count(tkoff_count),
    .drop_err(drop_err), .arb_state(arb_state)
`ifdef RUNWAY_TIMEOUT_EN
    , .timeout_err(timeout_err)
`endif
  );

  task automatic chk(string nm, int act, int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d want %0d", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_land(logic [3:0] id);
    land_req = 1'b1;
    land_id  = id;
    tick();
    land_req = 1'b0;
  endtask

  task automatic clear_rw();
    runway_clear = 1'b1;
    tick();
    runway_clear = 1'b0;
  endtask

  task automatic expect_gnt(logic [3:0] id, logic land);
    gnt_t g;
    g.id   = id;
    g.land = land;
    exp_q.push_back(g);
  endtask

  // Monitor: every grant pulse must match the head of the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && grant_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_grant_id", int'(grant_id), -1);
        end else begin
          gnt_t g;
          g = exp_q.pop_front();
          chk("grant_id", int'(grant_id), int'(g.id));
          chk("grant_is_land", int'(grant_is_land), int'(g.land));
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    land_req = 0; tkoff_req = 0; runway_clear = 0;
    land_id = 0; tkoff_id = 0;
    severe_weather = 0; emergency_landing_alert = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    chk("rst_state", int'(arb_state), 0);
    chk("rst_gv", int'(grant_valid), 0);
    chk("rst_gid", int'(grant_id), 0);
    chk("rst_lcnt", int'(land_count), 0);
    chk("rst_tcnt", int'(tkoff_count), 0);
    chk("rst_drop", int'(drop_err), 0);

    // Fairness: L1,L2,L3,T9 queued under lockdown -> 1,2,9,3
    emergency_landing_alert = 1;
    tick();
    chk("lock_state", int'(arb_state), 3);
    tkoff_req = 1; tkoff_id = 9;
    push_land(1);
    tkoff_req = 0;
    push_land(2);
    push_land(3);
    chk("fair_lcnt", int'(land_count), 3);
    chk("fair_tcnt", int'(tkoff_count), 1);
    emergency_landing_alert = 0;
    tick();
    chk("unlock_state", int'(arb_state), 0);
    expect_gnt(1, 1);
    expect_gnt(2, 1);
    expect_gnt(9, 0);
    expect_gnt(3, 1);
    repeat (4) begin
      tick();
      clear_rw();
    end
    chk("fair_drain", int'(land_count), 0);

    // Two landings back to back
    expect_gnt(1, 1);
    expect_gnt(2, 1);
    push_land(1);
    push_land(2);
    chk("l2_state_land", int'(arb_state), 1);
    chk("l2_lcnt", int'(land_count), 1);
    tick();
    chk("l2_hold_state", int'(arb_state), 1);
    chk("l2_gid_held", int'(grant_id), 1);
    clear_rw();
    chk("l2_idle", int'(arb_state), 0);
    tick();
    chk("l2_second_state", int'(arb_state), 1);
    chk("l2_second_gv", int'(grant_valid), 1);
    clear_rw();

    // Overflow: five pushes into lockdown queue
    emergency_landing_alert = 1;
    tick();
    push_land(3);
    push_land(4);
    push_land(5);
    push_land(6);
    chk("ovf_no_drop", int'(drop_err), 0);
    push_land(7);
    chk("ovf_lcnt", int'(land_count), 4);
    chk("ovf_drop", int'(drop_err), 1);
    tick();
    chk("ovf_drop_pulse", int'(drop_err), 0);
    emergency_landing_alert = 0;
    tick();
    expect_gnt(3, 1);
    expect_gnt(4, 1);
    expect_gnt(5, 1);
    expect_gnt(6, 1);
    repeat (4) begin
      tick();
      clear_rw();
    end

    // Severe weather holds takeoff 7
    severe_weather = 1;
    tkoff_req = 1; tkoff_id = 7;
    tick();
    tkoff_req = 0;
    repeat (3) tick();
    chk("wx_idle", int'(arb_state), 0);
    chk("wx_tcnt", int'(tkoff_count), 1);
    expect_gnt(7, 0);
    severe_weather = 0;
    tick();
    chk("wx_tkoff_state", int'(arb_state), 2);
    chk("wx_gv", int'(grant_valid), 1);
    clear_rw();

    // Alert during landing
    expect_gnt(5, 1);
    push_land(5);
    tick();
    chk("al_land", int'(arb_state), 1);
    emergency_landing_alert = 1;
    tick();
    chk("al_hold", int'(arb_state), 1);
    clear_rw();
    chk("al_idle", int'(arb_state), 0);
    tick();
    chk("al_lock", int'(arb_state), 3);
    runway_clear = 1;
    push_land(6);
    runway_clear = 0;
    chk("al_lock_clear_ign", int'(arb_state), 3);
    chk("al_lock_push", int'(land_count), 1);
    expect_gnt(6, 1);
    emergency_landing_alert = 0;
    tick();
    chk("al_release", int'(arb_state), 0);
    tick();
    chk("al_resume", int'(arb_state), 1);
    clear_rw();

    // Reset mid-landing with 3 queued
    expect_gnt(1, 1);
    push_land(1);
    push_land(2);
    push_land(3);
    push_land(4);
    chk("mr_land", int'(arb_state), 1);
    chk("mr_lcnt", int'(land_count), 3);
    rst = 1'b1;
    #2;
    chk("mr_state", int'(arb_state), 0);
    chk("mr_gid", int'(grant_id), 0);
    chk("mr_gil", int'(grant_is_land), 0);
    chk("mr_lcnt0", int'(land_count), 0);
    chk("mr_gv", int'(grant_valid), 0);
    tick();
    rst = 1'b0;
    tick();
    chk("mr_after", int'(arb_state), 0);

`ifdef RUNWAY_TIMEOUT_EN
    expect_gnt(8, 1);
    push_land(8);
    tick();
    chk("to_land", int'(arb_state), 1);
    repeat (15) tick();
    chk("to_before", int'(arb_state), 1);
    chk("to_err_low", int'(timeout_err), 0);
    tick();
    chk("to_idle", int'(arb_state), 0);
    chk("to_err", int'(timeout_err), 1);
    tick();
    chk("to_err_pulse", int'(timeout_err), 0);
`endif

    repeat (3) tick();
    chk("sb_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
